exe_stage: RTL and testbench

EXE_STAGE -- requirements
Module: exe_stage

---
 rtl/exe_stage.sv | 148 ++++++++++++++
 tb/tb_exe_stage.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/exe_stage.sv
// Execute stage: single-cycle ALU, load/store address generation and a 32-step
// iterative radix-2 divider that stalls the stage until its result is ready.
module exe_stage (
  input  logic         clk,
  input  logic         reset,
  input  logic         ms_allowin,
  output logic         es_allowin,
  input  logic         ds_to_es_valid,
  input  logic [137:0] ds_to_es_bus,
  output logic         es_to_ms_valid,
  output logic [70:0]  es_to_ms_bus,
  output logic         data_sram_en,
  output logic [3:0]   data_sram_we,
  output logic [31:0]  data_sram_addr,
  output logic [31:0]  data_sram_wdata
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} div_state_e;

  logic         r_es_valid;
  logic [137:0] r_bus;
  div_state_e   r_state;
  logic [4:0]   r_cnt;
  logic [31:0]  r_rem;
  logic [31:0]  r_quo;
  logic [31:0]  r_dsor;
  logic         r_q_neg;
  logic         r_r_neg;
  logic         r_dsor_zero;

  logic [31:0] w_pc, w_src1, w_src2, w_st_data;
  logic [3:0]  w_op;
  logic        w_gr_we;
  logic [4:0]  w_dest;
  logic        w_is_div, w_is_ld, w_is_st, w_div_signed, w_es_ready_go;
  logic [31:0] w_s1_abs, w_s2_abs;
  logic [32:0] w_sh;
  logic        w_ge;
  logic [31:0] w_diff;
  logic [31:0] w_div_q, w_div_r;
  logic [31:0] w_alu_res, w_result;

  assign w_pc      = r_bus[137:106];
  assign w_op      = r_bus[105:102];
  assign w_gr_we   = r_bus[101];
  assign w_dest    = r_bus[100:96];
  assign w_src1    = r_bus[95:64];
  assign w_src2    = r_bus[63:32];
  assign w_st_data = r_bus[31:0];

  assign w_is_div     = (w_op[3:2] == 2'b11);
  assign w_is_ld      = (w_op == 4'd10);
  assign w_is_st      = (w_op == 4'd11);
  assign w_div_signed = w_is_div & ~w_op[1];

  assign w_es_ready_go  = w_is_div ? (r_state == StDone) : 1'b1;
  assign es_allowin     = ~r_es_valid | (w_es_ready_go & ms_allowin);
  assign es_to_ms_valid = r_es_valid & w_es_ready_go;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_es_valid <= 1'b0;
      r_bus      <= '0;
    end else begin
      if (es_allowin) r_es_valid <= ds_to_es_valid;
      if (ds_to_es_valid && es_allowin) r_bus <= ds_to_es_bus;
    end
  end

  assign w_s1_abs = (w_div_signed && w_src1[31]) ? (32'd0 - w_src1) : w_src1;
  assign w_s2_abs = (w_div_signed && w_src2[31]) ? (32'd0 - w_src2) : w_src2;

  // Restoring step; partial remainder stays below the divisor, so 32 bits hold it.
  assign w_sh   = {r_rem, r_quo[31]};
  assign w_ge   = (w_sh >= {1'b0, r_dsor});
  assign w_diff = w_sh[31:0] - r_dsor;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_cnt       <= 5'd0;
      r_rem       <= 32'd0;
      r_quo       <= 32'd0;
      r_dsor      <= 32'd0;
      r_q_neg     <= 1'b0;
      r_r_neg     <= 1'b0;
      r_dsor_zero <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (r_es_valid && w_is_div) begin
            r_state     <= StBusy;
            r_cnt       <= 5'd0;
            r_rem       <= 32'd0;
            r_quo       <= w_s1_abs;
            r_dsor      <= w_s2_abs;
            r_q_neg     <= w_div_signed & (w_src1[31] ^ w_src2[31]);
            r_r_neg     <= w_div_signed & w_src1[31];
            r_dsor_zero <= (w_src2 == 32'd0);
          end
        end
        StBusy: begin
          r_rem <= w_ge ? w_diff : w_sh[31:0];
          r_quo <= {r_quo[30:0], w_ge};
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) r_state <= StDone;
        end
        StDone: begin
          if (ms_allowin) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // A zero divisor yields all-ones quotient; the remainder naturally equals the dividend.
  assign w_div_q = r_dsor_zero ? 32'hFFFF_FFFF : (r_q_neg ? (32'd0 - r_quo) : r_quo);
  assign w_div_r = r_r_neg ? (32'd0 - r_rem) : r_rem;

  always_comb begin
    w_alu_res = 32'd0;
    case (w_op)
      4'd0:  w_alu_res = w_src1 + w_src2;
      4'd1:  w_alu_res = w_src1 - w_src2;
      4'd2:  w_alu_res = w_src1 & w_src2;
      4'd3:  w_alu_res = w_src1 | w_src2;
      4'd4:  w_alu_res = w_src1 ^ w_src2;
      4'd5:  w_alu_res = {31'd0, $signed(w_src1) < $signed(w_src2)};
      4'd6:  w_alu_res = {31'd0, w_src1 < w_src2};
      4'd7:  w_alu_res = w_src1 << w_src2[4:0];
      4'd8:  w_alu_res = w_src1 >> w_src2[4:0];
      4'd9:  w_alu_res = $unsigned($signed(w_src1) >>> w_src2[4:0]);
      4'd10: w_alu_res = w_src1 + w_src2;
      4'd11: w_alu_res = w_src1 + w_src2;
      default: w_alu_res = 32'd0;
    endcase
  end

  assign w_result = w_is_div ? (w_op[0] ? w_div_r : w_div_q) : w_alu_res;

  assign es_to_ms_bus = {w_pc, w_is_ld, w_gr_we & ~w_is_st, w_dest, w_result};

  assign data_sram_en    = r_es_valid & (w_is_ld | w_is_st) & ms_allowin;
  assign data_sram_we    = (data_sram_en && w_is_st) ? 4'hF : 4'h0;
  assign data_sram_addr  = w_alu_res;
  assign data_sram_wdata = w_st_data;

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: ALU ops, load/store strobes, divider latency,
// signed/zero/overflow divide cases and reset in the middle of a division.
module tb_exe_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         ms_allowin;
  logic         es_allowin;
  logic         ds_to_es_valid;
  logic [137:0] ds_to_es_bus;
  logic         es_to_ms_valid;
  logic [70:0]  es_to_ms_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  int total = 0;
  int bad   = 0;

  exe_stage dut (
    .clk            (clk),
    .reset          (reset),
    .ms_allowin     (ms_allowin),
    .es_allowin     (es_allowin),
    .ds_to_es_valid (ds_to_es_valid),
    .ds_to_es_bus   (ds_to_es_bus),
    .es_to_ms_valid (es_to_ms_valid),
    .es_to_ms_bus   (es_to_ms_bus),
    .data_sram_en   (data_sram_en),
    .data_sram_we   (data_sram_we),
    .data_sram_addr (data_sram_addr),
    .data_sram_wdata(data_sram_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [70:0] obs, input logic [70:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [137:0] mk(input logic [3:0] op, input logic [31:0] s1,
                                      input logic [31:0] s2, input logic [31:0] sd);
    return {32'h1c00_0000 + {28'd0, op}, op, 1'b1, {1'b0, op} + 5'd1, s1, s2, sd};
  endfunction

  task automatic alu(input string tag, input logic [3:0] op, input logic [31:0] s1,
                     input logic [31:0] s2, input logic [31:0] exp);
    ds_to_es_valid = 1'b1;
    ds_to_es_bus   = mk(op, s1, s2, 32'd0);
    step();
    ds_to_es_valid = 1'b0;
    chk({tag, "_valid"}, 71'(es_to_ms_valid), 71'(1'b1));
    chk({tag, "_res"}, 71'(es_to_ms_bus[31:0]), 71'(exp));
  endtask

  // Returns in the cycle the result is first offered (expected T33).
  task automatic run_div(input string tag, input logic [3:0] op, input logic [31:0] s1,
                         input logic [31:0] s2, input logic [31:0] exp);
    int  cnt;
    logic alw_ok;
    ds_to_es_valid = 1'b1;
    ds_to_es_bus   = mk(op, s1, s2, 32'd0);
    step();
    ds_to_es_valid = 1'b0;
    cnt    = 0;
    alw_ok = 1'b1;
    while (!es_to_ms_valid && cnt < 60) begin
      if (es_allowin) alw_ok = 1'b0;
      step();
      cnt++;
    end
    chk({tag, "_latency"}, 71'(cnt), 71'(33));
    chk({tag, "_allowin_low"}, 71'(alw_ok), 71'(1'b1));
    chk({tag, "_res"}, 71'(es_to_ms_bus[31:0]), 71'(exp));
  endtask

  initial begin
    logic stale;
    reset          = 1'b1;
    ms_allowin     = 1'b1;
    ds_to_es_valid = 1'b1;
    ds_to_es_bus   = mk(4'd0, 32'd5, 32'd5, 32'd0);
    repeat (2) step();
    chk("rst_allowin", 71'(es_allowin), 71'(1'b1));
    chk("rst_valid", 71'(es_to_ms_valid), 71'(1'b0));
    chk("rst_en", 71'(data_sram_en), 71'(1'b0));
    chk("rst_we", 71'(data_sram_we), 71'(4'h0));
    chk("rst_bus", es_to_ms_bus, 71'(0));
    ds_to_es_valid = 1'b0;
    reset          = 1'b0;
    step();
    chk("idle_valid", 71'(es_to_ms_valid), 71'(1'b0));

    alu("add", 4'd0, 32'd5, 32'd7, 32'd12);
    chk("add_rfm", 71'(es_to_ms_bus[38]), 71'(1'b0));
    chk("add_grwe", 71'(es_to_ms_bus[37]), 71'(1'b1));
    chk("add_dest", 71'(es_to_ms_bus[36:32]), 71'(5'd1));
    chk("add_pc", 71'(es_to_ms_bus[70:39]), 71'(32'h1c00_0000));
    alu("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd2, 32'd1);
    alu("sub", 4'd1, 32'd5, 32'd7, 32'hFFFF_FFFE);
    alu("and", 4'd2, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);
    alu("or", 4'd3, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF);
    alu("xor", 4'd4, 32'h0000_00FF, 32'h0000_000F, 32'h0000_00F0);
    alu("slt", 4'd5, 32'hFFFF_FFFF, 32'd1, 32'd1);
    alu("sltu", 4'd6, 32'hFFFF_FFFF, 32'd1, 32'd0);
    alu("sll", 4'd7, 32'd1, 32'h0000_003F, 32'h8000_0000);
    alu("srl", 4'd8, 32'h8000_0000, 32'd4, 32'h0800_0000);
    alu("sra", 4'd9, 32'h8000_0000, 32'd4, 32'hF800_0000);

    alu("ld", 4'd10, 32'h0000_2000, 32'd8, 32'h0000_2008);
    chk("ld_rfm", 71'(es_to_ms_bus[38]), 71'(1'b1));
    chk("ld_en", 71'(data_sram_en), 71'(1'b1));
    chk("ld_we", 71'(data_sram_we), 71'(4'h0));
    chk("ld_addr", 71'(data_sram_addr), 71'(32'h0000_2008));

    ds_to_es_valid = 1'b1;
    ds_to_es_bus   = mk(4'd11, 32'h0000_1000, 32'd4, 32'hA5A5_A5A5);
    step();
    ds_to_es_valid = 1'b0;
    ms_allowin     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("st_stall_en", 71'(data_sram_en), 71'(1'b0));
      chk("st_stall_we", 71'(data_sram_we), 71'(4'h0));
      step();
    end
    ms_allowin = 1'b1;
    #1;
    chk("st_en", 71'(data_sram_en), 71'(1'b1));
    chk("st_we", 71'(data_sram_we), 71'(4'hF));
    chk("st_addr", 71'(data_sram_addr), 71'(32'h0000_1004));
    chk("st_wdata", 71'(data_sram_wdata), 71'(32'hA5A5_A5A5));
    chk("st_grwe", 71'(es_to_ms_bus[37]), 71'(1'b0));
    step();
    chk("st_gone_en", 71'(data_sram_en), 71'(1'b0));
    chk("st_gone_valid", 71'(es_to_ms_valid), 71'(1'b0));

    run_div("divw_neg", 4'd12, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_div("modw_neg", 4'd13, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_div("divwu_z", 4'd14, 32'd100, 32'd0, 32'hFFFF_FFFF);
    run_div("modwu_z", 4'd15, 32'd100, 32'd0, 32'd100);
    run_div("divw_ovf", 4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_div("modw_ovf", 4'd13, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run_div("divwu_big", 4'd14, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555);
    run_div("modw_pos", 4'd13, 32'd7, 32'hFFFF_FFFE, 32'd1);
    ms_allowin = 1'b0;
    repeat (2) step();
    chk("done_hold_valid", 71'(es_to_ms_valid), 71'(1'b1));
    chk("done_hold_res", 71'(es_to_ms_bus[31:0]), 71'(32'd1));
    ms_allowin = 1'b1;
    step();
    chk("done_left_valid", 71'(es_to_ms_valid), 71'(1'b0));

    ds_to_es_valid = 1'b1;
    ds_to_es_bus   = mk(4'd12, 32'hFFFF_FFF9, 32'd2, 32'd0);
    step();
    ds_to_es_valid = 1'b0;
    repeat (10) step();
    reset = 1'b1;
    #1;
    chk("midrst_valid", 71'(es_to_ms_valid), 71'(1'b0));
    chk("midrst_allowin", 71'(es_allowin), 71'(1'b1));
    chk("midrst_bus", es_to_ms_bus, 71'(0));
    step();
    reset = 1'b0;
    alu("post_rst_add", 4'd0, 32'd3, 32'd4, 32'd7);
    stale = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (es_to_ms_valid) stale = 1'b1;
    end
    chk("no_stale_div", 71'(stale), 71'(1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
